jk_monitor: RTL and testbench

JK_MONITOR -- requirements
Module: jk_monitor

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_next.sv | 25 ++
 rtl/jk_monitor.sv | 151 +++++++++++++++
 tb/tb_jk_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop monitor: the monitor state
// encoding and the two-bit {j,k} mode constants.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

endpackage

// File: rtl/jk_next.sv
// Purely combinational JK next-state function. The monitor uses one
// instance for both seeding from the observed q and advancing its own
// expected value.
module jk_next
    import jk_pkg::*;
(
    input  logic j,
    input  logic k,
    input  logic qcur,
    output logic qnext
);

    // Characteristic equation of a JK flip-flop selected by the {j,k} mode
    always_comb begin
        qnext = qcur;
        case ({j, k})
            HOLD:    qnext = qcur;
            RST:     qnext = 1'b0;
            SET:     qnext = 1'b1;
            TGL:     qnext = ~qcur;
            default: qnext = qcur;
        endcase
    end

endmodule

// File: rtl/jk_monitor.sv
// JK flip-flop monitor: predicts the observed flip-flop output one cycle
// ahead, compares it, counts checked and failing cycles (saturating),
// and records which JK modes have been exercised.
// Build option: define JKMON_QD_CHECK_EN to also require qd == ~q on every
// compared cycle; without it qd is ignored.
module jk_monitor
    import jk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             qd,
    output logic             err,
    output logic             err_pulse,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic       exp_q;
    logic       exp_q_nxt;
    logic       qcur_sel;
    logic       q_pred;
    logic       seeding;
    logic       comparing;
    logic       qd_bad;
    logic       mismatch;
    logic [3:0] cov_nxt;

    assign seeding   = en && (state == SYNC);
    assign comparing = en && ((state == CHECK) || (state == FAIL));

    // In SYNC the prediction is seeded from the real q; afterwards the
    // monitor advances its own expected value so a single fault is not
    // silently absorbed into the prediction.
    assign qcur_sel = (state == SYNC) ? q : exp_q;

    jk_next u_next (
        .j     (j),
        .k     (k),
        .qcur  (qcur_sel),
        .qnext (q_pred)
    );

`ifdef JKMON_QD_CHECK_EN
    assign qd_bad = (qd == q);
`else
    // qd is intentionally left dangling in this build; this net has no load.
    logic unused_qd;
    assign unused_qd = qd;
    assign qd_bad    = 1'b0;
`endif

    // A mismatched q and a non-complementary qd on the same cycle count once
    assign mismatch = comparing && ((q != exp_q) || qd_bad);

    assign done = (&cov) && !err;

    // Next-state logic; once an error has been seen the block re-enters
    // FAIL rather than CHECK after a pause, so only clr or rst clear it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en)
                    state_nxt = SYNC;
            end
            SYNC: begin
                if (!en)
                    state_nxt = IDLE;
                else if (err)
                    state_nxt = FAIL;
                else
                    state_nxt = CHECK;
            end
            CHECK: begin
                if (!en)
                    state_nxt = IDLE;
                else if (mismatch)
                    state_nxt = FAIL;
            end
            FAIL: begin
                if (!en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    // Next expected value and coverage bit for the current {j,k} sample
    always_comb begin
        exp_q_nxt = exp_q;
        cov_nxt   = cov;
        if (seeding || comparing) begin
            exp_q_nxt         = q_pred;
            cov_nxt[{j, k}]   = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Prediction, flags, coverage and saturating counters; clr beats a
    // simultaneous mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q     <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            cov       <= '0;
        end else if (clr) begin
            exp_q     <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            cov       <= '0;
        end else begin
            exp_q     <= exp_q_nxt;
            cov       <= cov_nxt;
            err_pulse <= mismatch;
            if (mismatch)
                err <= 1'b1;
            if (comparing && !(&chk_cnt))
                chk_cnt <= chk_cnt + CNT_ONE;
            if (mismatch && !(&err_cnt))
                err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_jk_monitor.sv
// Self-checking bench for jk_monitor: a JK flip-flop with injectable
// faults drives two monitors (8-bit and 4-bit counters); a behavioural
// model predicts every output, plus directed scenarios with literal values.
module tb_jk_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       j;
    logic       k;
    logic       q;
    logic       qd;

    logic       err;
    logic       err_pulse;
    logic [7:0] chk_cnt;
    logic [7:0] err_cnt;
    logic [3:0] cov;
    logic       done;

    logic       err4;
    logic       err_pulse4;
    logic [3:0] chk_cnt4;
    logic [3:0] err_cnt4;
    logic [3:0] cov4;
    logic       done4;

    logic       ff_q     = 1'b0;
    logic       fault_q  = 1'b0;
    logic       fault_qd = 1'b0;

    int         n_cmp    = 0;
    int         n_bad    = 0;
    bit         checking = 1'b0;

    // model state
    int         m_chk    = 0;
    int         m_err    = 0;
    bit [3:0]   m_cov    = 4'b0;
    bit         m_errf   = 1'b0;
    bit         m_pulse  = 1'b0;
    bit         m_exp    = 1'b0;
    bit         m_mis    = 1'b0;
    int         run_len  = 0;

    assign q  = ff_q ^ fault_q;
    assign qd = ~ff_q ^ fault_qd;

    jk_monitor #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .j         (j),
        .k         (k),
        .q         (q),
        .qd        (qd),
        .err       (err),
        .err_pulse (err_pulse),
        .chk_cnt   (chk_cnt),
        .err_cnt   (err_cnt),
        .cov       (cov),
        .done      (done)
    );

    jk_monitor #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .j         (j),
        .k         (k),
        .q         (q),
        .qd        (qd),
        .err       (err4),
        .err_pulse (err_pulse4),
        .chk_cnt   (chk_cnt4),
        .err_cnt   (err_cnt4),
        .cov       (cov4),
        .done      (done4)
    );

    always #5 clk = ~clk;

    function automatic bit jk_eval(input bit jj, input bit kk, input bit qq);
        if (jj && kk) return !qq;
        if (jj)       return 1'b1;
        if (kk)       return 1'b0;
        return qq;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // The observed device: an ideal JK flip-flop
    always @(posedge clk) ff_q <= jk_eval(j, k, ff_q);

    // Behavioural model: counts consecutive enabled edges since the monitor
    // last went idle; the first only wakes it, the second seeds the
    // prediction, every later one is a compared cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_chk = 0; m_err = 0; m_cov = 4'b0; m_errf = 1'b0;
            m_pulse = 1'b0; m_exp = 1'b0; run_len = 0;
        end else begin
            m_mis = 1'b0;
            if (clr) begin
                m_chk = 0; m_err = 0; m_cov = 4'b0; m_errf = 1'b0;
                m_exp = 1'b0; run_len = 0;
            end else if (!en) begin
                run_len = 0;
            end else begin
                if (run_len == 1) begin
                    m_exp = jk_eval(j, k, q);
                    m_cov[{j, k}] = 1'b1;
                end else if (run_len >= 2) begin
`ifdef JKMON_QD_CHECK_EN
                    m_mis = (q != m_exp) || (qd == q);
`else
                    m_mis = (q != m_exp);
`endif
                    m_chk++;
                    m_cov[{j, k}] = 1'b1;
                    if (m_mis) begin
                        m_errf = 1'b1;
                        m_err++;
                    end
                    m_exp = jk_eval(j, k, m_exp);
                end
                if (run_len < 2) run_len++;
            end
            m_pulse = m_mis;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Compare both monitors against the model
    task automatic checkOutput();
        check("err",        err,        m_errf);
        check("err_pulse",  err_pulse,  m_pulse);
        check("chk_cnt",    chk_cnt,    sat(m_chk, 255));
        check("err_cnt",    err_cnt,    sat(m_err, 255));
        check("cov",        cov,        m_cov);
        check("done",       done,       (&m_cov) && !m_errf);
        check("err4",       err4,       m_errf);
        check("err_pulse4", err_pulse4, m_pulse);
        check("chk_cnt4",   chk_cnt4,   sat(m_chk, 15));
        check("err_cnt4",   err_cnt4,   sat(m_err, 15));
        check("cov4",       cov4,       m_cov);
    endtask

    // Per-cycle compare process, away from the active edge
    always @(negedge clk) if (checking) checkOutput();

    // Drive one edge worth of inputs, then return just after that edge
    task automatic applyStimulus(input bit a_en, input bit a_clr, input bit a_j,
                                 input bit a_k, input bit a_fq, input bit a_fqd,
                                 input bit a_rst);
        en = a_en; clr = a_clr; j = a_j; k = a_k;
        fault_q = a_fq; fault_qd = a_fqd; rst = a_rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; j = 1'b0; k = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        check("lit_reset_chk",  chk_cnt, 0);
        check("lit_reset_cov",  cov, 0);
        check("lit_reset_done", done, 0);

        // Four CHECK cycles covering every mode with a correct flip-flop
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        check("lit_seq_chk",  chk_cnt, 4);
        check("lit_seq_err",  err_cnt, 0);
        check("lit_seq_cov",  cov, 4'hF);
        check("lit_seq_done", done, 1);

        // Drive exp_q to 0, then force q high: one mismatch
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        check("lit_fault_pulse",  err_pulse, 1);
        check("lit_fault_err",    err, 1);
        check("lit_fault_errcnt", err_cnt, 1);
        check("lit_fault_done",   done, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        check("lit_fault_pulse_end", err_pulse, 0);
        check("lit_fault_errcnt2",   err_cnt, 1);

        // clr on the same edge as a mismatch
        applyStimulus(1, 1, 0, 0, 1, 0, 0);
        check("lit_clr_err",    err, 0);
        check("lit_clr_errcnt", err_cnt, 0);
        check("lit_clr_pulse",  err_pulse, 0);
        check("lit_clr_chk",    chk_cnt, 0);

        // 20 correct compares: 4-bit counter saturates, 8-bit does not
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
        check("lit_sat_chk4", chk_cnt4, 15);
        check("lit_sat_chk8", chk_cnt, 20);
        check("lit_sat_err4", err_cnt4, 0);

        // qd equal to q for one cycle while q is correct
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
`ifdef JKMON_QD_CHECK_EN
        check("lit_qd_errcnt", err_cnt, 1);
`else
        check("lit_qd_errcnt", err_cnt, 0);
`endif

        // Asynchronous reset mid-compare clears outputs at once
        applyStimulus(1, 0, 1, 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("lit_rst_err",    err, 0);
        check("lit_rst_pulse",  err_pulse, 0);
        check("lit_rst_chk",    chk_cnt, 0);
        check("lit_rst_errcnt", err_cnt, 0);
        check("lit_rst_cov",    cov, 0);
        check("lit_rst_done",   done, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 99) < 92,
                          $urandom_range(0, 299) == 0,
                          $urandom_range(0, 1),
                          $urandom_range(0, 1),
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 399) == 0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
